// File: rtl/ascii_int_decoder.sv
// ascii_int_decoder
//   Converts a UART byte stream of signed decimal tokens into DATA_W-bit
//   two's-complement values. It checks each token against [VAL_MIN, VAL_MAX],
//   reports rejected tokens with an error code, and collapses CR/LF pairs into
//   one newline. It also counts the valid tokens on each line.
//
//   Optional feature: define ASCII_HEX_INPUT_EN to accept "0x"/"0X" prefixed
//   hexadecimal tokens. When it is undefined, 'x' is an ordinary bad char.
//
// Ports
//   clk             in   system clock
//   rst             in   synchronous, active-high reset
//   uart_data[7:0]  in   received byte, valid while uart_done=1
//   uart_done       in   one-cycle strobe per received byte
//   out_value       out  last accepted value, held until the next out_valid
//   out_valid       out  pulse: out_value updated
//   out_space       out  pulse: space delimiter seen
//   out_newline     out  pulse: end of line
//   out_line_tokens out  valid tokens in the line just ended (with out_newline)
//   out_err         out  pulse: token rejected
//   err_code[1:0]   out  01 BADCHAR, 10 TOO_LONG, 11 RANGE; held until next out_err
module ascii_int_decoder #(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = 5,
  parameter int VAL_MIN    = -32768,
  parameter int VAL_MAX    = 32767,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        uart_data,
  input  logic              uart_done,
  output logic [DATA_W-1:0] out_value,
  output logic              out_valid,
  output logic              out_space,
  output logic              out_newline,
  output logic [CNT_W-1:0]  out_line_tokens,
  output logic              out_err,
  output logic [1:0]        err_code
);

  localparam int                     DGW     = $clog2(MAX_DIGITS + 1);
  localparam logic [DGW-1:0]         DG_MAX  = DGW'(MAX_DIGITS);
  localparam logic signed [DATA_W:0] V_LO    = (DATA_W+1)'(VAL_MIN);
  localparam logic signed [DATA_W:0] V_HI    = (DATA_W+1)'(VAL_MAX);
  localparam logic [CNT_W-1:0]       CNT_SAT = {CNT_W{1'b1}};
  localparam logic [1:0]             E_BAD   = 2'b01;
  localparam logic [1:0]             E_LONG  = 2'b10;
  localparam logic [1:0]             E_RANGE = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, SIGN = 2'd1, NUM = 2'd2, SKIP = 2'd3} state_t;

  state_t           state, state_nx;
  logic [DATA_W:0]  mag, mag_nx;
  logic [DGW-1:0]   cnt, cnt_nx;
  logic             neg, neg_nx;
  logic             cr_flag, cr_nx;
  logic [CNT_W-1:0] line_cnt, line_nx;

  logic              valid_nx, space_nx, nl_nx, err_nx;
  logic [1:0]        code_nx;
  logic [DATA_W-1:0] value_nx;
  logic [CNT_W-1:0]  tokens_nx;

  // Character classes
  logic is_digit, is_minus, is_space, is_lf, is_cr, is_delim;
  assign is_digit = (uart_data >= 8'h30) && (uart_data <= 8'h39);
  assign is_minus = (uart_data == 8'h2D);
  assign is_space = (uart_data == 8'h20);
  assign is_lf    = (uart_data == 8'h0A);
  assign is_cr    = (uart_data == 8'h0D);
  assign is_delim = is_space || is_lf || is_cr;

  // Digit recognition depends on the current radix
  logic       tok_digit, hex_mode, hex_enter;
  logic [3:0] tok_nib;
`ifdef ASCII_HEX_INPUT_EN
  logic hex, hex_nx;
  logic is_lc_hex, is_uc_hex, is_x;
  assign is_lc_hex = (uart_data >= 8'h61) && (uart_data <= 8'h66);
  assign is_uc_hex = (uart_data >= 8'h41) && (uart_data <= 8'h46);
  assign is_x      = (uart_data == 8'h78) || (uart_data == 8'h58);
  assign hex_mode  = hex;
  assign tok_digit = hex ? (is_digit || is_lc_hex || is_uc_hex) : is_digit;
  // 'a'/'A' carry low nibble 1, so +9 maps them to 10
  assign tok_nib   = is_digit ? uart_data[3:0] : (uart_data[3:0] + 4'd9);
  // Only a bare unsigned "0" may switch to hex
  assign hex_enter = (state == NUM) && !hex && (cnt == DGW'(1)) &&
                     (mag == {(DATA_W+1){1'b0}}) && !neg && is_x;
`else
  assign hex_mode  = 1'b0;
  assign tok_digit = is_digit;
  assign tok_nib   = uart_data[3:0];
  assign hex_enter = 1'b0;
`endif

  // Token arithmetic; the accumulator is one bit wider than the output, so it cannot wrap
  logic [DATA_W:0]  mag_dig, tok_val;
  logic             in_range, hex_empty, flush, accept, nl_ev;
  logic [CNT_W-1:0] line_inc;
  assign mag_dig   = mag * (hex_mode ? (DATA_W+1)'(16) : (DATA_W+1)'(10)) + (DATA_W+1)'(tok_nib);
  assign tok_val   = neg ? -mag : mag;
  assign in_range  = ($signed(tok_val) >= V_LO) && ($signed(tok_val) <= V_HI);
  assign hex_empty = hex_mode && (cnt == {DGW{1'b0}});
  assign flush     = uart_done && (state == NUM) && is_delim && !hex_empty;
  assign accept    = flush && in_range;
  assign nl_ev     = uart_done && (is_cr || (is_lf && !cr_flag));
  assign line_inc  = (line_cnt == CNT_SAT) ? line_cnt : line_cnt + CNT_W'(1);

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mag             <= {(DATA_W+1){1'b0}};
      cnt             <= {DGW{1'b0}};
      neg             <= 1'b0;
      cr_flag         <= 1'b0;
      line_cnt        <= {CNT_W{1'b0}};
      out_value       <= {DATA_W{1'b0}};
      out_valid       <= 1'b0;
      out_space       <= 1'b0;
      out_newline     <= 1'b0;
      out_line_tokens <= {CNT_W{1'b0}};
      out_err         <= 1'b0;
      err_code        <= 2'b00;
`ifdef ASCII_HEX_INPUT_EN
      hex             <= 1'b0;
`endif
    end else begin
      state           <= state_nx;
      mag             <= mag_nx;
      cnt             <= cnt_nx;
      neg             <= neg_nx;
      cr_flag         <= cr_nx;
      line_cnt        <= line_nx;
      out_value       <= value_nx;
      out_valid       <= valid_nx;
      out_space       <= space_nx;
      out_newline     <= nl_nx;
      out_line_tokens <= tokens_nx;
      out_err         <= err_nx;
      err_code        <= code_nx;
`ifdef ASCII_HEX_INPUT_EN
      hex             <= hex_nx;
`endif
    end
  end

  // Next state and token datapath
  always_comb begin
    state_nx = state;
    mag_nx   = mag;
    cnt_nx   = cnt;
    neg_nx   = neg;
    cr_nx    = cr_flag;
    line_nx  = line_cnt;
`ifdef ASCII_HEX_INPUT_EN
    hex_nx   = hex;
`endif
    if (uart_done) begin
      // An LF following CR is consumed and also ends the pair
      cr_nx = is_cr;
      if (nl_ev) line_nx = {CNT_W{1'b0}};
      else if (accept) line_nx = line_inc;
      else line_nx = line_cnt;
      case (state)
        IDLE: begin
          if (is_digit) begin
            mag_nx = (DATA_W+1)'(uart_data[3:0]); cnt_nx = DGW'(1); neg_nx = 1'b0; state_nx = NUM;
          end else if (is_minus) begin
            neg_nx = 1'b1; state_nx = SIGN;
          end else if (is_delim) state_nx = IDLE;
          else state_nx = SKIP;
        end
        SIGN: begin
          if (is_digit) begin
            mag_nx = (DATA_W+1)'(uart_data[3:0]); cnt_nx = DGW'(1); state_nx = NUM;
          end else if (is_delim) state_nx = IDLE;
          else state_nx = SKIP;
        end
        NUM: begin
          if (hex_enter) begin
            cnt_nx = {DGW{1'b0}};
`ifdef ASCII_HEX_INPUT_EN
            hex_nx = 1'b1;
`endif
          end else if (tok_digit) begin
            if (cnt == DG_MAX) state_nx = SKIP;
            else begin
              mag_nx = mag_dig; cnt_nx = cnt + DGW'(1);
            end
          end else if (is_delim) state_nx = IDLE;
          else state_nx = SKIP;
        end
        SKIP: begin
          if (is_delim) state_nx = IDLE;
          else state_nx = SKIP;
        end
        default: state_nx = IDLE;
      endcase
`ifdef ASCII_HEX_INPUT_EN
      if (state_nx != NUM) hex_nx = 1'b0;
      else hex_nx = hex_nx;
`endif
    end else begin
      state_nx = state;
    end
  end

  // Output pulses and held values for the next cycle
  always_comb begin
    valid_nx  = 1'b0;
    space_nx  = 1'b0;
    nl_nx     = 1'b0;
    err_nx    = 1'b0;
    code_nx   = err_code;
    value_nx  = out_value;
    tokens_nx = out_line_tokens;
    if (uart_done) begin
      space_nx = is_space;
      nl_nx    = nl_ev;
      // The line count includes a token flushed by the newline byte itself
      if (nl_ev) tokens_nx = accept ? line_inc : line_cnt;
      else tokens_nx = out_line_tokens;
      case (state)
        IDLE: begin
          if (!is_digit && !is_minus && !is_delim) begin
            err_nx = 1'b1; code_nx = E_BAD;
          end else err_nx = 1'b0;
        end
        SIGN: begin
          if (!is_digit) begin
            err_nx = 1'b1; code_nx = E_BAD;
          end else err_nx = 1'b0;
        end
        NUM: begin
          if (hex_enter) err_nx = 1'b0;
          else if (tok_digit) begin
            if (cnt == DG_MAX) begin
              err_nx = 1'b1; code_nx = E_LONG;
            end else err_nx = 1'b0;
          end else if (is_delim) begin
            if (hex_empty) begin
              err_nx = 1'b1; code_nx = E_BAD;
            end else if (in_range) begin
              valid_nx = 1'b1; value_nx = tok_val[DATA_W-1:0];
            end else begin
              err_nx = 1'b1; code_nx = E_RANGE;
            end
          end else begin
            err_nx = 1'b1; code_nx = E_BAD;
          end
        end
        SKIP: err_nx = 1'b0;
        default: err_nx = 1'b0;
      endcase
    end else begin
      err_nx = 1'b0;
    end
  end

endmodule

// File: tb/tb_ascii_int_decoder.sv
// Directed bench for ascii_int_decoder. It checks pulses, held values and
// reset behaviour with immediate assertions. Define ASCII_HEX_INPUT_EN to
// exercise the hex token path.
module tb_ascii_int_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  uart_data;
  logic        uart_done;
  logic [31:0] out_value;
  logic        out_valid, out_space, out_newline, out_err;
  logic [7:0]  out_line_tokens;
  logic [1:0]  err_code;

  int n_assert = 0;
  int n_fail   = 0;

  ascii_int_decoder dut (
    .clk(clk), .rst(rst), .uart_data(uart_data), .uart_done(uart_done),
    .out_value(out_value), .out_valid(out_valid), .out_space(out_space),
    .out_newline(out_newline), .out_line_tokens(out_line_tokens),
    .out_err(out_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one byte and check the pulses {valid, space, newline, err} that follow it
  task automatic step(input string tag, input logic [7:0] b, input logic [3:0] p);
    uart_data = b;
    uart_done = 1'b1;
    @(posedge clk);
    #1;
    uart_done = 1'b0;
    chk(tag, {60'd0, out_valid, out_space, out_newline, out_err}, {60'd0, p});
  endtask

  initial begin
    rst = 1'b1; uart_done = 1'b0; uart_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulses", {60'd0, out_valid, out_space, out_newline, out_err}, 64'd0);
    chk("rst_value", {32'd0, out_value}, 64'd0);
    chk("rst_tokens_code", {54'd0, out_line_tokens, err_code}, 64'd0);
    rst = 1'b0;

    // "12 -345\r\n"
    step("t1_1", 8'h31, 4'b0000);
    step("t1_2", 8'h32, 4'b0000);
    step("t1_sp", 8'h20, 4'b1100);
    chk("t1_val12", {32'd0, out_value}, 64'd12);
    step("t1_minus", 8'h2D, 4'b0000);
    step("t1_3", 8'h33, 4'b0000);
    step("t1_4", 8'h34, 4'b0000);
    step("t1_5", 8'h35, 4'b0000);
    step("t1_cr", 8'h0D, 4'b1010);
    chk("t1_val_neg", {32'd0, out_value}, {32'd0, 32'hFFFFFEA7});
    chk("t1_tokens", {56'd0, out_line_tokens}, 64'd2);
    step("t1_lf", 8'h0A, 4'b0000);

    // "123456 7\n"
    step("t2_1", 8'h31, 4'b0000);
    step("t2_2", 8'h32, 4'b0000);
    step("t2_3", 8'h33, 4'b0000);
    step("t2_4", 8'h34, 4'b0000);
    step("t2_5", 8'h35, 4'b0000);
    step("t2_6", 8'h36, 4'b0001);
    chk("t2_code_long", {62'd0, err_code}, 64'd2);
    step("t2_sp", 8'h20, 4'b0100);
    step("t2_7", 8'h37, 4'b0000);
    step("t2_lf", 8'h0A, 4'b1010);
    chk("t2_val7", {32'd0, out_value}, 64'd7);
    chk("t2_tokens", {56'd0, out_line_tokens}, 64'd1);

    // "40000 -32768\n"
    step("t3_4", 8'h34, 4'b0000);
    step("t3_0a", 8'h30, 4'b0000);
    step("t3_0b", 8'h30, 4'b0000);
    step("t3_0c", 8'h30, 4'b0000);
    step("t3_0d", 8'h30, 4'b0000);
    step("t3_sp", 8'h20, 4'b0101);
    chk("t3_code_range", {62'd0, err_code}, 64'd3);
    chk("t3_val_held", {32'd0, out_value}, 64'd7);
    step("t3_minus", 8'h2D, 4'b0000);
    step("t3_3", 8'h33, 4'b0000);
    step("t3_2", 8'h32, 4'b0000);
    step("t3_7", 8'h37, 4'b0000);
    step("t3_6", 8'h36, 4'b0000);
    step("t3_8", 8'h38, 4'b0000);
    step("t3_lf", 8'h0A, 4'b1010);
    chk("t3_val_min", {32'd0, out_value}, {32'd0, 32'hFFFF8000});
    chk("t3_tokens", {56'd0, out_line_tokens}, 64'd1);

    // "1a2 - 9\n"
    step("t4_1", 8'h31, 4'b0000);
    step("t4_a", 8'h61, 4'b0001);
    chk("t4_code_bad", {62'd0, err_code}, 64'd1);
    step("t4_2", 8'h32, 4'b0000);
    step("t4_sp1", 8'h20, 4'b0100);
    step("t4_minus", 8'h2D, 4'b0000);
    step("t4_sp2", 8'h20, 4'b0101);
    step("t4_9", 8'h39, 4'b0000);
    step("t4_lf", 8'h0A, 4'b1010);
    chk("t4_val9", {32'd0, out_value}, 64'd9);
    chk("t4_tokens", {56'd0, out_line_tokens}, 64'd1);

    // "32767 -32769\n": upper bound accepted, one below lower bound rejected
    step("b_3", 8'h33, 4'b0000);
    step("b_2", 8'h32, 4'b0000);
    step("b_7a", 8'h37, 4'b0000);
    step("b_6", 8'h36, 4'b0000);
    step("b_7b", 8'h37, 4'b0000);
    step("b_sp", 8'h20, 4'b1100);
    chk("b_val_max", {32'd0, out_value}, 64'd32767);
    step("b_minus", 8'h2D, 4'b0000);
    step("b_n3", 8'h33, 4'b0000);
    step("b_n2", 8'h32, 4'b0000);
    step("b_n7", 8'h37, 4'b0000);
    step("b_n6", 8'h36, 4'b0000);
    step("b_n9", 8'h39, 4'b0000);
    step("b_lf", 8'h0A, 4'b0011);
    chk("b_code_range", {62'd0, err_code}, 64'd3);
    chk("b_val_held", {32'd0, out_value}, 64'd32767);
    chk("b_tokens", {56'd0, out_line_tokens}, 64'd1);

`ifdef ASCII_HEX_INPUT_EN
    // "0x1F 0x\n"
    step("h_0", 8'h30, 4'b0000);
    step("h_x", 8'h78, 4'b0000);
    step("h_1", 8'h31, 4'b0000);
    step("h_F", 8'h46, 4'b0000);
    step("h_sp", 8'h20, 4'b1100);
    chk("h_val31", {32'd0, out_value}, 64'd31);
    step("h_0b", 8'h30, 4'b0000);
    step("h_xb", 8'h78, 4'b0000);
    step("h_lf", 8'h0A, 4'b0011);
    chk("h_code_bad", {62'd0, err_code}, 64'd1);
`else
    // "0x\n": 'x' is an ordinary bad char
    step("x_0", 8'h30, 4'b0000);
    step("x_x", 8'h78, 4'b0001);
    chk("x_code_bad", {62'd0, err_code}, 64'd1);
    step("x_lf", 8'h0A, 4'b0010);
`endif

    // "\n\r\r\n": three newlines, no tokens
    step("t5_lf1", 8'h0A, 4'b0010);
    chk("t5_tok1", {56'd0, out_line_tokens}, 64'd0);
    step("t5_cr1", 8'h0D, 4'b0010);
    step("t5_cr2", 8'h0D, 4'b0010);
    step("t5_lf2", 8'h0A, 4'b0000);
    chk("t5_tok2", {56'd0, out_line_tokens}, 64'd0);

    // "55" with rst asserted during the second '5'
    step("t5_5a", 8'h35, 4'b0000);
    uart_data = 8'h35; uart_done = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    uart_done = 1'b0; rst = 1'b0;
    chk("t5_rst_pulses", {60'd0, out_valid, out_space, out_newline, out_err}, 64'd0);
    chk("t5_rst_value", {32'd0, out_value}, 64'd0);
    chk("t5_rst_tok_code", {54'd0, out_line_tokens, err_code}, 64'd0);
    step("t5_post_lf", 8'h0A, 4'b0010);
    chk("t5_post_val", {32'd0, out_value}, 64'd0);
    chk("t5_post_tok", {56'd0, out_line_tokens}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
